uni_rr_arbiter: RTL and testbench
=================================

Name: uni_rr_arbiter

Overview:
- Shares one downstream unified memory port (uni protocol, 128-bit line width) between N upstream requesters, e.g. iCache miss port, dCache miss port, and a future DMA/uncached port.
- Selects one requester by round-robin, registers the grant, and locks it until the downstream valid/ready handshake completes.
- Sits between the cache wrappers and uni2axi. It replaces the fixed two-way select with a fair, N-way, transaction-locked scheduler.

Parameters:
- N_REQ, 2, number of upstream requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 128, wdata/rdata width.
- SIZE_W, 3, size field width.
- TYP_W, 1, reqtyp width (0 = read, 1 = write).
- ID_W, $clog2(N_REQ) with a minimum of 1, grant index width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_s_valid  in  N_REQ  per-requester request valid.
- o_s_ready  out  N_REQ  per-requester completion; one-cycle pulse.
- i_s_reqtyp  in  N_REQ*TYP_W  packed, requester k occupies slice [k*TYP_W +: TYP_W].
- i_s_addr  in  N_REQ*ADDR_W  packed.
- i_s_wdata  in  N_REQ*DATA_W  packed.
- i_s_size  in  N_REQ*SIZE_W  packed.
- i_s_cachable  in  N_REQ  packed.
- o_s_rdata  out  N_REQ*DATA_W  packed; only the granted slice is nonzero.
- o_m_valid  out  1  downstream valid.
- i_m_ready  in  1  downstream completion.
- o_m_reqtyp, o_m_addr, o_m_wdata, o_m_size, o_m_cachable  out  TYP_W/ADDR_W/DATA_W/SIZE_W/1  muxed request fields.
- i_m_rdata  in  DATA_W  downstream read data.
- o_gnt_id  out  ID_W  current or last grant index.
- o_busy  out  1  a transaction is locked.

Behaviour:
- Reset is synchronous and active-low: sampled on the rising edge of i_clk while i_rst_n = 0.
  - Reset values: state = IDLE, o_m_valid = 0, o_s_ready = 0, o_s_rdata = 0, o_gnt_id = 0, o_busy = 0.
  - Round-robin pointer last = N_REQ-1, so requester 0 has top priority after reset.
- States: IDLE and BUSY, held in a single state register.
- IDLE:
  - If any i_s_valid bit is set, pick the first set bit scanning from last+1 upward with wrap-around.
  - Register the pick into gnt and go to BUSY.
  - If no valid bit is set, stay in IDLE.
  - o_m_valid = 0 throughout IDLE.
- BUSY:
  - o_m_valid = i_s_valid[gnt]. All o_m_* fields are combinationally muxed from slice gnt.
  - o_busy = 1.
- Completion: in BUSY, o_m_valid & i_m_ready in the same cycle causes all of the following:
  - o_s_ready[gnt] = 1 combinationally in that cycle, with o_s_rdata slice gnt = i_m_rdata and all other slices 0.
  - last <= gnt, and next state = IDLE.
- Latency:
  - A request first seen in IDLE at cycle t drives o_m_valid at t+1.
  - At least one IDLE cycle separates consecutive transactions (no back-to-back grant in the completion cycle).
- Protocol rules for requesters:
  - A requester holds valid and all fields stable until its ready.
  - A requester must not raise valid in the cycle after its ready unless it issues a new request.
- Abort: if the granted requester drops i_s_valid while in BUSY without a handshake, then:
  - o_m_valid falls the same cycle and next state = IDLE.
  - last is updated to gnt and no ready is issued.
- Fairness:
  - With all N_REQ requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0.
  - Maximum wait is N_REQ-1 transactions.
- Non-granted requesters see o_s_ready = 0 and rdata = 0.
  - New valids that arrive during BUSY are held off and do not disturb the locked grant.
- o_gnt_id = gnt, which keeps its value in IDLE.
- Reset mid-transaction: reset in BUSY forces IDLE and o_m_valid = 0 on the next edge. The downstream side is reset by the same reset.
- i_m_ready while o_m_valid = 0 is ignored.

Decomposition:
- Package uni_arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e.
  - Constants UNI_RD = 1'b0 and UNI_WR = 1'b1.
- Sub-module rr_pick #(N): purely combinational.
  - Inputs: req[N], last[ID_W].
  - Outputs: any, idx[ID_W].
  - Implementation: double-width masked priority encoder.
- The top level holds the FSM, the gnt/last registers and the field muxes. State/gnt registers use stl_reg-style enabled flops with synchronous reset.

Test Plan:
- Reset, N_REQ=2: apply i_rst_n=0 for 2 cycles with i_s_valid=2'b11 → o_m_valid=0, o_s_ready=0, o_busy=0. After release, the first grant is id 0.
- Single read: req0 valid at t with addr 0x8000_0040, reqtyp 0. Downstream asserts ready at t+3 with rdata 128'hDEAD…BEEF.
  - Required: o_m_valid=1 at t+1..t+3, o_m_addr=0x8000_0040.
  - At t+3: o_s_ready=2'b01 and slice0 = DEAD…BEEF.
- Contention: both requesters valid continuously, ready returned after 2 cycles each → grant sequence 0,1,0,1. Each ready pulses exactly once per transaction, with one IDLE bubble between transactions.
- Write passthrough: req1 write with addr 0x8000_1000, wdata 128'h1, size 3 while req0 idle → o_m_reqtyp=1, o_m_wdata=128'h1, o_m_size=3, o_gnt_id=1.
- Abort: req0 granted, then drops valid at BUSY cycle 2 with no ready → o_m_valid=0 that cycle and state returns to IDLE. If req1 is pending, req1 is granted next.
- Mid-transaction reset, N_REQ=4: all four requesters valid; assert reset in BUSY while gnt=2 → IDLE next edge, last=3, and the first post-reset grant is 0.

Source files
------------

// File: rtl/uni_arb_pkg.sv
// Shared types and constants for the unified-port round-robin arbiter.
package uni_arb_pkg;

  // Arbiter lock state: IDLE picks a requester, BUSY holds the grant.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // reqtyp encoding on the uni protocol.
  localparam logic UNI_RD = 1'b0;
  localparam logic UNI_WR = 1'b1;

  // Grant index width; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic            any,
  output logic [ID_W-1:0] idx
);

  logic [2*N-1:0] dbl;

  // Double-width masked priority encoder: bits above 'last' in the doubled
  // vector, lowest index wins, folded back modulo N.
  always_comb begin
    dbl = {req, req};
    any = |req;
    idx = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i] && (i > int'(last))) begin
        idx = ID_W'(i % N);
      end
    end
  end

endmodule

// File: rtl/uni_rr_arbiter.sv
// N-way round-robin arbiter in front of one uni memory port. A grant is
// registered in IDLE and locked in BUSY until the downstream handshake
// (o_m_valid & i_m_ready) or until the granted requester drops its valid.
//
// Handshake: downstream completes a transfer in the cycle where o_m_valid
// and i_m_ready are both high; that same cycle the granted requester sees a
// one-cycle o_s_ready pulse with read data, and the arbiter returns to IDLE.
module uni_rr_arbiter
  import uni_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int SIZE_W = 3,
  parameter int TYP_W  = 1,
  parameter int ID_W   = id_width(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_s_valid,
  output logic [N_REQ-1:0]        o_s_ready,
  input  logic [N_REQ*TYP_W-1:0]  i_s_reqtyp,
  input  logic [N_REQ*ADDR_W-1:0] i_s_addr,
  input  logic [N_REQ*DATA_W-1:0] i_s_wdata,
  input  logic [N_REQ*SIZE_W-1:0] i_s_size,
  input  logic [N_REQ-1:0]        i_s_cachable,
  output logic [N_REQ*DATA_W-1:0] o_s_rdata,
  output logic                    o_m_valid,
  input  logic                    i_m_ready,
  output logic [TYP_W-1:0]        o_m_reqtyp,
  output logic [ADDR_W-1:0]       o_m_addr,
  output logic [DATA_W-1:0]       o_m_wdata,
  output logic [SIZE_W-1:0]       o_m_size,
  output logic                    o_m_cachable,
  input  logic [DATA_W-1:0]       i_m_rdata,
  output logic [ID_W-1:0]         o_gnt_id,
  output logic                    o_busy
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0] last_q, last_d;
  logic            gnt_en, last_en;
  logic            pick_any;
  logic [ID_W-1:0] pick_idx;
  logic            sel_valid;
  logic            hs;
  int              sel;

  rr_pick #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req  (i_s_valid),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // State register, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  // Grant register, loaded only when a new grant is issued.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    gnt_q <= '0;
    else if (gnt_en) gnt_q <= gnt_d;
  end

  // Round-robin pointer; resets to N_REQ-1 so requester 0 goes first.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)     last_q <= ID_W'(N_REQ-1);
    else if (last_en) last_q <= last_d;
  end

  // Next-state logic: grant in IDLE, release on handshake or abort in BUSY.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_en    = 1'b0;
    last_d    = last_q;
    last_en   = 1'b0;
    sel       = int'(gnt_q);
    sel_valid = i_s_valid[gnt_q];
    hs        = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          gnt_en  = 1'b1;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!sel_valid) begin
          // Requester withdrew: release without a ready pulse.
          last_d  = gnt_q;
          last_en = 1'b1;
          state_d = ARB_IDLE;
        end else if (i_m_ready) begin
          hs      = 1'b1;
          last_d  = gnt_q;
          last_en = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Request field muxes and completion steering toward the granted slice.
  always_comb begin
    o_m_valid    = (state_q == ARB_BUSY) && sel_valid;
    o_busy       = (state_q == ARB_BUSY);
    o_gnt_id     = gnt_q;
    o_m_reqtyp   = i_s_reqtyp[sel*TYP_W +: TYP_W];
    o_m_addr     = i_s_addr[sel*ADDR_W +: ADDR_W];
    o_m_wdata    = i_s_wdata[sel*DATA_W +: DATA_W];
    o_m_size     = i_s_size[sel*SIZE_W +: SIZE_W];
    o_m_cachable = i_s_cachable[gnt_q];
    o_s_ready    = '0;
    o_s_rdata    = '0;
    if (hs) begin
      o_s_ready[gnt_q] = 1'b1;
      o_s_rdata[sel*DATA_W +: DATA_W] = i_m_rdata;
    end
  end

endmodule

// File: tb/tb_uni_rr_arbiter.sv
// Directed bench for uni_rr_arbiter: N_REQ=2 for reset, contention, abort,
// single read and write passthrough; N_REQ=4 for reset mid-transaction.
module tb_uni_rr_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- N_REQ = 2 instance ----------------
  logic         rst2_n;
  logic [1:0]   v2, rdy2;
  logic [1:0]   typ2;
  logic [63:0]  addr2;
  logic [255:0] wdata2, rdata2;
  logic [5:0]   size2;
  logic [1:0]   cach2;
  logic         m_valid2, m_ready2, m_typ2, m_cach2;
  logic [31:0]  m_addr2;
  logic [127:0] m_wdata2, m_rdata2;
  logic [2:0]   m_size2;
  logic [0:0]   gnt2;
  logic         busy2;

  uni_rr_arbiter #(.N_REQ(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst2_n),
    .i_s_valid(v2), .o_s_ready(rdy2), .i_s_reqtyp(typ2), .i_s_addr(addr2),
    .i_s_wdata(wdata2), .i_s_size(size2), .i_s_cachable(cach2), .o_s_rdata(rdata2),
    .o_m_valid(m_valid2), .i_m_ready(m_ready2), .o_m_reqtyp(m_typ2),
    .o_m_addr(m_addr2), .o_m_wdata(m_wdata2), .o_m_size(m_size2),
    .o_m_cachable(m_cach2), .i_m_rdata(m_rdata2), .o_gnt_id(gnt2), .o_busy(busy2)
  );

  // ---------------- N_REQ = 4 instance ----------------
  logic         rst4_n;
  logic [3:0]   v4, rdy4;
  logic [3:0]   typ4;
  logic [127:0] addr4;
  logic [511:0] wdata4, rdata4;
  logic [11:0]  size4;
  logic [3:0]   cach4;
  logic         m_valid4, m_ready4, m_typ4, m_cach4;
  logic [31:0]  m_addr4;
  logic [127:0] m_wdata4, m_rdata4;
  logic [2:0]   m_size4;
  logic [1:0]   gnt4;
  logic         busy4;

  uni_rr_arbiter #(.N_REQ(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst4_n),
    .i_s_valid(v4), .o_s_ready(rdy4), .i_s_reqtyp(typ4), .i_s_addr(addr4),
    .i_s_wdata(wdata4), .i_s_size(size4), .i_s_cachable(cach4), .o_s_rdata(rdata4),
    .o_m_valid(m_valid4), .i_m_ready(m_ready4), .o_m_reqtyp(m_typ4),
    .o_m_addr(m_addr4), .o_m_wdata(m_wdata4), .o_m_size(m_size4),
    .o_m_cachable(m_cach4), .i_m_rdata(m_rdata4), .o_gnt_id(gnt4), .o_busy(busy4)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One contention transaction starting in an IDLE cycle: bubble, grant,
  // ready on the second BUSY cycle.
  task automatic txn2(input int exp_id);
    logic [127:0] pat;
    logic [1:0]   exp_rdy;
    pat     = {4{32'hA5A5_0000 + 32'(exp_id)}};
    exp_rdy = 2'b01 << exp_id;
    @(negedge clk);
    check_eq("cont_bubble_valid", 128'(m_valid2), 128'd0);
    check_eq("cont_bubble_busy", 128'(busy2), 128'd0);
    tick();
    @(negedge clk);
    check_eq("cont_gnt", 128'(gnt2), 128'(exp_id));
    check_eq("cont_valid_b1", 128'(m_valid2), 128'd1);
    check_eq("cont_addr", 128'(m_addr2), 128'(32'h100 * (exp_id + 1)));
    check_eq("cont_rdy_b1", 128'(rdy2), 128'd0);
    tick();
    m_ready2 = 1'b1;
    m_rdata2 = pat;
    @(negedge clk);
    check_eq("cont_rdy_hs", 128'(rdy2), 128'(exp_rdy));
    check_eq("cont_rdata_gnt", rdata2[exp_id*128 +: 128], pat);
    check_eq("cont_rdata_other", rdata2[(1-exp_id)*128 +: 128], 128'd0);
    tick();
    m_ready2 = 1'b0;
    m_rdata2 = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst2_n = 1'b0; v2 = 2'b11; typ2 = '0; wdata2 = '0; size2 = '0; cach2 = 2'b01;
    addr2 = {32'h200, 32'h100};
    m_ready2 = 1'b0; m_rdata2 = '0;
    rst4_n = 1'b0; v4 = '0; typ4 = '0; wdata4 = '0; size4 = '0; cach4 = '0;
    m_ready4 = 1'b0; m_rdata4 = '0;
    for (int k = 0; k < 4; k++) addr4[k*32 +: 32] = 32'h40 + 32'h10 * k;

    // Reset with both requesters asking.
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      check_eq("rst_m_valid", 128'(m_valid2), 128'd0);
      check_eq("rst_s_ready", 128'(rdy2), 128'd0);
      check_eq("rst_busy", 128'(busy2), 128'd0);
      check_eq("rst_gnt", 128'(gnt2), 128'd0);
    end
    @(posedge clk); #1;
    rst2_n = 1'b1;

    // Contention: both valid continuously, grants alternate.
    txn2(0);
    txn2(1);
    txn2(0);
    txn2(1);

    // Abort: req0 granted, drops valid on BUSY cycle 2; req1 pending.
    tick();
    @(negedge clk);
    check_eq("abort_gnt0", 128'(gnt2), 128'd0);
    check_eq("abort_valid_b1", 128'(m_valid2), 128'd1);
    tick();
    v2 = 2'b10;
    @(negedge clk);
    check_eq("abort_valid_drop", 128'(m_valid2), 128'd0);
    check_eq("abort_no_ready", 128'(rdy2), 128'd0);
    tick();
    @(negedge clk);
    check_eq("abort_idle", 128'(busy2), 128'd0);
    tick();
    @(negedge clk);
    check_eq("abort_next_gnt", 128'(gnt2), 128'd1);
    check_eq("abort_next_valid", 128'(m_valid2), 128'd1);
    tick();
    m_ready2 = 1'b1;
    @(negedge clk);
    check_eq("abort_next_rdy", 128'(rdy2), 128'b10);
    tick();
    m_ready2 = 1'b0;
    v2 = 2'b00;

    // Downstream ready with nothing in flight is ignored.
    m_ready2 = 1'b1;
    @(negedge clk);
    check_eq("stray_ready", 128'(rdy2), 128'd0);
    tick();
    m_ready2 = 1'b0;

    // Single read on req0.
    addr2[31:0] = 32'h8000_0040;
    typ2[0] = 1'b0;
    v2 = 2'b01;
    @(negedge clk);
    check_eq("rd_t0_valid", 128'(m_valid2), 128'd0);
    tick();
    @(negedge clk);
    check_eq("rd_t1_valid", 128'(m_valid2), 128'd1);
    check_eq("rd_t1_addr", 128'(m_addr2), 128'h8000_0040);
    check_eq("rd_t1_typ", 128'(m_typ2), 128'd0);
    check_eq("rd_t1_cach", 128'(m_cach2), 128'd1);
    tick();
    @(negedge clk);
    check_eq("rd_t2_valid", 128'(m_valid2), 128'd1);
    check_eq("rd_t2_rdy", 128'(rdy2), 128'd0);
    tick();
    m_ready2 = 1'b1;
    m_rdata2 = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
    @(negedge clk);
    check_eq("rd_t3_valid", 128'(m_valid2), 128'd1);
    check_eq("rd_t3_rdy", 128'(rdy2), 128'b01);
    check_eq("rd_t3_slice0", rdata2[127:0], 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF);
    check_eq("rd_t3_slice1", rdata2[255:128], 128'd0);
    tick();
    m_ready2 = 1'b0;
    m_rdata2 = '0;
    v2 = 2'b00;
    @(negedge clk);
    check_eq("rd_t4_valid", 128'(m_valid2), 128'd0);
    check_eq("rd_t4_gnt_hold", 128'(gnt2), 128'd0);

    // Write passthrough on req1; req0 arrives mid-transaction and waits.
    tick();
    typ2[1] = 1'b1;
    addr2[63:32] = 32'h8000_1000;
    wdata2[255:128] = 128'h1;
    size2[5:3] = 3'd3;
    v2 = 2'b10;
    tick();
    @(negedge clk);
    check_eq("wr_typ", 128'(m_typ2), 128'd1);
    check_eq("wr_addr", 128'(m_addr2), 128'h8000_1000);
    check_eq("wr_wdata", m_wdata2, 128'h1);
    check_eq("wr_size", 128'(m_size2), 128'd3);
    check_eq("wr_gnt", 128'(gnt2), 128'd1);
    check_eq("wr_cach", 128'(m_cach2), 128'd0);
    tick();
    v2 = 2'b11;
    @(negedge clk);
    check_eq("wr_lock_gnt", 128'(gnt2), 128'd1);
    tick();
    m_ready2 = 1'b1;
    @(negedge clk);
    check_eq("wr_rdy", 128'(rdy2), 128'b10);
    tick();
    m_ready2 = 1'b0;
    v2 = 2'b01;
    tick();
    @(negedge clk);
    check_eq("wr_then_req0", 128'(gnt2), 128'd0);
    v2 = 2'b00;

    // N_REQ=4: reset while granted to requester 2.
    rst4_n = 1'b0;
    v4 = 4'hF;
    tick();
    tick();
    rst4_n = 1'b1;
    for (int g = 0; g < 2; g++) begin
      tick();
      m_ready4 = 1'b1;
      @(negedge clk);
      check_eq("n4_gnt", 128'(gnt4), 128'(g));
      check_eq("n4_rdy", 128'(rdy4), 128'(4'b0001 << g));
      tick();
      m_ready4 = 1'b0;
    end
    tick();
    rst4_n = 1'b0;
    @(negedge clk);
    check_eq("n4_gnt2", 128'(gnt4), 128'd2);
    check_eq("n4_busy_pre", 128'(busy4), 128'd1);
    tick();
    @(negedge clk);
    check_eq("n4_rst_valid", 128'(m_valid4), 128'd0);
    check_eq("n4_rst_busy", 128'(busy4), 128'd0);
    rst4_n = 1'b1;
    tick();
    @(negedge clk);
    check_eq("n4_post_gnt", 128'(gnt4), 128'd0);
    check_eq("n4_post_valid", 128'(m_valid4), 128'd1);
    check_eq("n4_post_addr", 128'(m_addr4), 128'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
